// File: rtl/reg_wb.sv
// CPU15 write-back stage: eight general registers plus a per-register
// pending-write scoreboard that tells decode when a source is still in flight.
module reg_wb #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 2
) (
    input  logic             CLK_WB,
    input  logic             RESET,
    input  logic             WB_EN,
    input  logic [2:0]       N_REG_WB,
    input  logic [WIDTH-1:0] REG_IN,
    input  logic             LOCK_EN,
    input  logic [2:0]       N_REG_LOCK,
    input  logic [2:0]       N_REG_CHK,
    output logic [WIDTH-1:0] REG_0,
    output logic [WIDTH-1:0] REG_1,
    output logic [WIDTH-1:0] REG_2,
    output logic [WIDTH-1:0] REG_3,
    output logic [WIDTH-1:0] REG_4,
    output logic [WIDTH-1:0] REG_5,
    output logic [WIDTH-1:0] REG_6,
    output logic [WIDTH-1:0] REG_7,
    output logic [7:0]       BUSY,
    output logic             STALL,
    output logic             LOCK_ERR
);

    localparam int unsigned NREG = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [CNT_W-1:0] cnt_q  [NREG];
    logic [CNT_W-1:0] cnt_d  [NREG];
    logic [NREG-1:0]  inc, dec;
    logic [NREG-1:0]  busy_q, busy_d;
    logic             lock_err_q, lock_err_d;

    // Scoreboard next state: a lock and a retirement on the same register cancel.
    always_comb begin
        lock_err_d = lock_err_q;
        inc        = '0;
        dec        = '0;
        busy_d     = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            inc[i]   = LOCK_EN && (N_REG_LOCK == 3'(i));
            dec[i]   = WB_EN && (N_REG_WB == 3'(i)) && (cnt_q[i] != '0);
            if (inc[i] && !dec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    lock_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec[i] && !inc[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            busy_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge CLK_WB) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            busy_q     <= '0;
            lock_err_q <= 1'b0;
        end else begin
            if (WB_EN) begin
                regs_q[N_REG_WB] <= REG_IN;
            end
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            busy_q     <= busy_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign REG_0    = regs_q[0];
    assign REG_1    = regs_q[1];
    assign REG_2    = regs_q[2];
    assign REG_3    = regs_q[3];
    assign REG_4    = regs_q[4];
    assign REG_5    = regs_q[5];
    assign REG_6    = regs_q[6];
    assign REG_7    = regs_q[7];
    assign BUSY     = busy_q;
    assign STALL    = busy_q[N_REG_CHK];
    assign LOCK_ERR = lock_err_q;

endmodule

// File: tb/tb_reg_wb.sv
// Directed bench for reg_wb: register writes, scoreboard locking, saturation
// and mid-operation reset, each checked against hand-computed values.
module tb_reg_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [2:0]  n_reg_wb;
    logic [15:0] reg_in;
    logic        lock_en;
    logic [2:0]  n_reg_lock;
    logic [2:0]  n_reg_chk;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [7:0]  busy;
    logic        stall;
    logic        lock_err;

    int vectors = 0;
    int miscompares = 0;

    reg_wb #(.WIDTH(16), .CNT_W(2)) dut (
        .CLK_WB(clk), .RESET(reset), .WB_EN(wb_en), .N_REG_WB(n_reg_wb),
        .REG_IN(reg_in), .LOCK_EN(lock_en), .N_REG_LOCK(n_reg_lock),
        .N_REG_CHK(n_reg_chk),
        .REG_0(r0), .REG_1(r1), .REG_2(r2), .REG_3(r3),
        .REG_4(r4), .REG_5(r5), .REG_6(r6), .REG_7(r7),
        .BUSY(busy), .STALL(stall), .LOCK_ERR(lock_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd(input int i);
        case (i)
            0: rd = r0; 1: rd = r1; 2: rd = r2; 3: rd = r3;
            4: rd = r4; 5: rd = r5; 6: rd = r6; default: rd = r7;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_en = 1'b0; lock_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); n_reg_wb = '0; reg_in = '0; n_reg_lock = '0; n_reg_chk = '0;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (rd(i) !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_reg%0d: got %h want 0000", i, rd(i));
            end
        end
        vectors++;
        if (busy !== 8'h00) begin miscompares++; $display("FAIL reset_busy: got %h want 00", busy); end
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
        vectors++;
        if (lock_err !== 1'b0) begin miscompares++; $display("FAIL reset_lockerr: got %b want 0", lock_err); end
    endtask

    task automatic test_write();
        wb_en = 1'b1; n_reg_wb = 3'd3; reg_in = 16'hABCD;
        step();
        idle();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (rd(i) !== ((i == 3) ? 16'hABCD : 16'h0000)) begin
                miscompares++;
                $display("FAIL write_reg%0d: got %h want %h", i, rd(i), (i == 3) ? 16'hABCD : 16'h0000);
            end
        end
        vectors++;
        if (busy !== 8'h00 || lock_err !== 1'b0) begin
            miscompares++; $display("FAIL write_busy: got %h/%b want 00/0", busy, lock_err);
        end
        // no bypass: new data is not visible before the edge
        wb_en = 1'b1; n_reg_wb = 3'd3; reg_in = 16'h1234;
        #2;
        vectors++;
        if (r3 !== 16'hABCD) begin miscompares++; $display("FAIL no_bypass: got %h want abcd", r3); end
        step();
        idle();
        vectors++;
        if (r3 !== 16'h1234) begin miscompares++; $display("FAIL overwrite: got %h want 1234", r3); end
    endtask

    task automatic test_lock();
        lock_en = 1'b1; n_reg_lock = 3'd5;
        step();
        idle(); n_reg_chk = 3'd5;
        #1;
        vectors++;
        if (busy !== 8'h20 || stall !== 1'b1) begin
            miscompares++; $display("FAIL lock_busy: got %h/%b want 20/1", busy, stall);
        end
        n_reg_chk = 3'd4;
        #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL lock_other_stall: got %b want 0", stall); end
        n_reg_chk = 3'd5;
        wb_en = 1'b1; n_reg_wb = 3'd5; reg_in = 16'h0042;
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL stall_same_cycle: got %b want 1", stall); end
        step();
        idle();
        vectors++;
        if (stall !== 1'b0 || r5 !== 16'h0042 || busy !== 8'h00) begin
            miscompares++; $display("FAIL lock_release: got %b/%h/%h want 0/0042/00", stall, r5, busy);
        end
    endtask

    task automatic test_back_to_back();
        lock_en = 1'b1; n_reg_lock = 3'd2;
        step();
        lock_en = 1'b1; n_reg_lock = 3'd2; wb_en = 1'b1; n_reg_wb = 3'd2; reg_in = 16'h1111;
        step();
        idle();
        vectors++;
        if (busy !== 8'h04 || r2 !== 16'h1111) begin
            miscompares++; $display("FAIL lock_wb_same: got %h/%h want 04/1111", busy, r2);
        end
        wb_en = 1'b1; n_reg_wb = 3'd2; reg_in = 16'h2222;
        step();
        idle();
        vectors++;
        if (busy !== 8'h00 || r2 !== 16'h2222 || lock_err !== 1'b0) begin
            miscompares++; $display("FAIL lock_wb_cnt1: got %h/%h/%b want 00/2222/0", busy, r2, lock_err);
        end
    endtask

    task automatic test_saturate();
        for (int k = 1; k <= 4; k++) begin
            lock_en = 1'b1; n_reg_lock = 3'd1;
            step();
            idle();
            vectors++;
            if (busy !== 8'h02 || lock_err !== (k == 4)) begin
                miscompares++;
                $display("FAIL sat_lock%0d: got %h/%b want 02/%b", k, busy, lock_err, k == 4);
            end
        end
        // first retirement of r1 alongside an independent lock of r0
        wb_en = 1'b1; n_reg_wb = 3'd1; reg_in = 16'h0101; lock_en = 1'b1; n_reg_lock = 3'd0;
        step(); idle();
        vectors++;
        if (busy !== 8'h03 || lock_err !== 1'b1 || r1 !== 16'h0101) begin
            miscompares++; $display("FAIL sat_wb1: got %h/%b/%h want 03/1/0101", busy, lock_err, r1);
        end
        wb_en = 1'b1; n_reg_wb = 3'd1; reg_in = 16'h0202;
        step(); idle();
        vectors++;
        if (busy !== 8'h03 || lock_err !== 1'b1) begin
            miscompares++; $display("FAIL sat_wb2: got %h/%b want 03/1", busy, lock_err);
        end
        wb_en = 1'b1; n_reg_wb = 3'd1; reg_in = 16'h0303;
        step(); idle();
        vectors++;
        if (busy !== 8'h01 || lock_err !== 1'b1 || r1 !== 16'h0303) begin
            miscompares++; $display("FAIL sat_wb3: got %h/%b/%h want 01/1/0303", busy, lock_err, r1);
        end
        wb_en = 1'b1; n_reg_wb = 3'd0; reg_in = 16'h0A0A;
        step(); idle();
        vectors++;
        if (busy !== 8'h00 || lock_err !== 1'b1 || r0 !== 16'h0A0A) begin
            miscompares++; $display("FAIL sat_wb_r0: got %h/%b/%h want 00/1/0a0a", busy, lock_err, r0);
        end
    endtask

    task automatic test_reset_mid();
        wb_en = 1'b1; n_reg_wb = 3'd4; reg_in = 16'h5555;
        step(); idle();
        vectors++;
        if (r4 !== 16'h5555 || busy !== 8'h00) begin
            miscompares++; $display("FAIL unsched_wb: got %h/%h want 5555/00", r4, busy);
        end
        lock_en = 1'b1; n_reg_lock = 3'd4;
        step();
        lock_en = 1'b1; n_reg_lock = 3'd6;
        step(); idle();
        vectors++;
        if (busy !== 8'h50) begin miscompares++; $display("FAIL mid_locks: got %h want 50", busy); end
        reset = 1'b1; wb_en = 1'b1; n_reg_wb = 3'd4; reg_in = 16'hFFFF;
        step();
        reset = 1'b0; idle(); n_reg_chk = 3'd4;
        #1;
        vectors++;
        if (busy !== 8'h00 || r4 !== 16'h0000 || lock_err !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got %h/%h/%b/%b want 00/0000/0/0", busy, r4, lock_err, stall);
        end
        vectors++;
        if (r0 !== 16'h0000 || r1 !== 16'h0000 || r5 !== 16'h0000) begin
            miscompares++; $display("FAIL reset_mid_regs: got %h/%h/%h want 0000", r0, r1, r5);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_lock();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
